booth_prod_accum: RTL and testbench

Sequential accumulate stage directly downstream of the combinational radix-4 Booth multiplier (8x8 signed -> 16-bit signed product).
- Accepts one signed product per valid/ready handshake.
- Sums NUM_TERMS consecutive products into a saturating signed accumulator, then holds the frame result on an output handshake.
- Forms the MAC back-end for dot-product style use of the multiplier.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_sat_add.sv | 39 +++
 rtl/booth_prod_accum.sv | 96 +++++++++
 tb/tb_booth_prod_accum.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier accumulate back-end.
// Covers the state encoding, the default widths and the saturation limit helpers.
package booth_pkg;

  typedef enum logic {
    StAccum = 1'b0,
    StHold  = 1'b1
  } state_e;

  localparam int unsigned DefProdW = 16;
  localparam int unsigned DefAccW  = 24;

  // Largest signed value representable in 'width' bits.
  function automatic longint sat_max(int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative signed value representable in 'width' bits.
  function automatic longint sat_min(int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed accumulate step: adds a sign-extended product to the
// accumulator one bit wider, clips to the ACC_W range and flags any clipping.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned PROD_W = DefProdW
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  localparam int unsigned ExtW = ACC_W + 1;
  localparam logic signed [ACC_W:0] SumMax = ExtW'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] SumMin = ExtW'(sat_min(ACC_W));

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] prod_ext;
  logic signed [ACC_W:0] sum_ext;

  assign acc_ext  = $signed({acc_i[ACC_W-1], acc_i});
  assign prod_ext = $signed({{(ExtW - PROD_W){prod_i[PROD_W-1]}}, prod_i});

  always_comb begin
    sum_ext = acc_ext + prod_ext;
    sum_o   = sum_ext[ACC_W-1:0];
    ovf_o   = 1'b0;
    if (sum_ext > SumMax) begin
      sum_o = SumMax[ACC_W-1:0];
      ovf_o = 1'b1;
    end else if (sum_ext < SumMin) begin
      sum_o = SumMin[ACC_W-1:0];
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/booth_prod_accum.sv
// Saturating frame accumulator behind the radix-4 Booth multiplier: sums
// NUM_TERMS products per frame and presents the result on a valid/ready port.
module booth_prod_accum
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W    = DefProdW,
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned NUM_TERMS = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              prod_vld_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic              prod_rdy_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic              acc_vld_o,
  input  logic              acc_rdy_i,
  output logic              ovf_o,
  output logic [CNT_W-1:0]  term_cnt_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_TERMS - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ACC_W-1:0]   sum;
  logic               sum_ovf;
  logic               prod_xfer;
  logic               res_xfer;

  booth_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc_i  (acc_q),
    .prod_i (prod_i),
    .sum_o  (sum),
    .ovf_o  (sum_ovf)
  );

  assign prod_rdy_o = (state_q == StAccum);
  assign acc_vld_o  = (state_q == StHold);
  assign prod_xfer  = prod_vld_i & prod_rdy_o;
  assign res_xfer   = acc_vld_o & acc_rdy_i;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    // clr_i wins over both handshakes; a product offered alongside it is dropped.
    if (clr_i) begin
      state_d = StAccum;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else if (res_xfer) begin
      state_d = StAccum;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (prod_xfer) begin
      acc_d = sum;
      ovf_d = ovf_q | sum_ovf;
      if (cnt_q == LastCnt) begin
        cnt_d   = '0;
        state_d = StHold;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StAccum;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_o      = acc_q;
  assign ovf_o      = ovf_q;
  assign term_cnt_o = cnt_q;

endmodule

// File: tb/tb_booth_prod_accum.sv
// Scoreboard bench: three configurations (24-bit/4 terms, 16-bit/4 terms,
// 16-bit/1 term) share one stimulus stream and are checked against a frame model.
module tb_booth_prod_accum;

  typedef struct {
    int     idx;
    longint acc;
    bit     ovf;
  } res_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               prod_vld;
  logic signed [15:0] prod;
  logic               acc_rdy;

  logic [2:0]         rdy;
  logic [2:0]         vld;
  logic [2:0]         ovf;
  logic [7:0]         cnt0, cnt1, cnt2;
  logic signed [23:0] acc0;
  logic signed [15:0] acc1, acc2;

  int   total = 0;
  int   bad   = 0;
  res_t sb[$];

  int     acc_w[3] = '{24, 16, 16};
  int     terms[3] = '{4, 4, 1};
  bit     m_hold[3];
  longint m_sum[3];
  bit     m_ovf[3];
  int     m_cnt[3];

  always #5 clk = ~clk;

  booth_prod_accum #(.PROD_W(16), .ACC_W(24), .NUM_TERMS(4), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .prod_vld_i(prod_vld), .prod_i(prod),
    .prod_rdy_o(rdy[0]), .acc_o(acc0), .acc_vld_o(vld[0]), .acc_rdy_i(acc_rdy),
    .ovf_o(ovf[0]), .term_cnt_o(cnt0)
  );

  booth_prod_accum #(.PROD_W(16), .ACC_W(16), .NUM_TERMS(4), .CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .prod_vld_i(prod_vld), .prod_i(prod),
    .prod_rdy_o(rdy[1]), .acc_o(acc1), .acc_vld_o(vld[1]), .acc_rdy_i(acc_rdy),
    .ovf_o(ovf[1]), .term_cnt_o(cnt1)
  );

  booth_prod_accum #(.PROD_W(16), .ACC_W(16), .NUM_TERMS(1), .CNT_W(8)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .prod_vld_i(prod_vld), .prod_i(prod),
    .prod_rdy_o(rdy[2]), .acc_o(acc2), .acc_vld_o(vld[2]), .acc_rdy_i(acc_rdy),
    .ovf_o(ovf[2]), .term_cnt_o(cnt2)
  );

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [63:0] get_acc(input int i);
    case (i)
      0:       return 64'(acc0);
      1:       return 64'(acc1);
      default: return 64'(acc2);
    endcase
  endfunction

  function automatic logic signed [63:0] get_cnt(input int i);
    case (i)
      0:       return 64'(cnt0);
      1:       return 64'(cnt1);
      default: return 64'(cnt2);
    endcase
  endfunction

  // Frame-level reference: plain integer sum clamped to the configured range.
  task automatic model_step(input int i);
    longint s, hi, lo;
    hi = (longint'(1) << (acc_w[i] - 1)) - 1;
    lo = -(longint'(1) << (acc_w[i] - 1));
    if (!rst_n || clr) begin
      m_hold[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
    end else if (m_hold[i]) begin
      if (acc_rdy) begin
        m_hold[i] = 0; m_sum[i] = 0; m_ovf[i] = 0;
      end
    end else if (prod_vld) begin
      s = m_sum[i] + longint'(prod);
      if (s > hi) begin
        s = hi; m_ovf[i] = 1;
      end else if (s < lo) begin
        s = lo; m_ovf[i] = 1;
      end
      m_sum[i] = s;
      m_cnt[i]++;
      if (m_cnt[i] == terms[i]) begin
        m_cnt[i]  = 0;
        m_hold[i] = 1;
        sb.push_back('{i, s, m_ovf[i]});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_hold[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  // Monitor: per-cycle state checks plus scoreboard pop on each new result.
  initial begin
    bit prev_vld[3] = '{0, 0, 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("dut%0d rdy", i), 64'(rdy[i]), 64'(!m_hold[i]));
        chk($sformatf("dut%0d vld", i), 64'(vld[i]), 64'(m_hold[i]));
        chk($sformatf("dut%0d cnt", i), get_cnt(i), 64'(m_cnt[i]));
        chk($sformatf("dut%0d acc", i), get_acc(i), m_sum[i]);
        if (vld[i] === 1'b1 && !prev_vld[i]) begin
          int k = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].idx == i) begin
              k = j;
              break;
            end
          end
          if (k < 0) begin
            total++; bad++;
            $display("FAIL dut%0d result: got unexpected acc=%0d want none", i, get_acc(i));
          end else begin
            chk($sformatf("dut%0d sb acc", i), get_acc(i), sb[k].acc);
            chk($sformatf("dut%0d sb ovf", i), 64'(ovf[i]), 64'(sb[k].ovf));
            sb.delete(k);
          end
        end
        prev_vld[i] = (vld[i] === 1'b1);
      end
    end
  end

  task automatic put(input int p);
    prod     = 16'(p);
    prod_vld = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    prod_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear();
    clr      = 1'b1;
    prod_vld = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; prod_vld = 1'b0; prod = '0; acc_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset acc", 64'(acc0), 0);
    chk("reset vld", 64'(vld[0]), 0);
    chk("reset rdy", 64'(rdy[0]), 1);
    rst_n = 1'b1;

    // Basic four-term frame.
    put(-40);  chk("t1 cnt1", 64'(cnt0), 1);
    put(100);  chk("t1 cnt2", 64'(cnt0), 2);
    put(-20);  chk("t1 cnt3", 64'(cnt0), 3);
    put(7);    chk("t1 cnt0", 64'(cnt0), 0);
    chk("t1 acc", 64'(acc0), 47);
    chk("t1 vld", 64'(vld[0]), 1);
    chk("t1 ovf", 64'(ovf[0]), 0);
    idle();

    // Positive saturation at 16 bits.
    clear();
    repeat (4) put(16384);
    chk("t2 acc", 64'(acc1), 32767);
    chk("t2 ovf", 64'(ovf[1]), 1);
    idle();
    chk("t2 next ovf", 64'(ovf[1]), 0);
    chk("t2 next vld", 64'(vld[1]), 0);

    // Negative saturation and single-term frame.
    clear();
    repeat (4) put(-16384);
    chk("t6 acc", 64'(acc1), -32768);
    chk("t6 ovf", 64'(ovf[1]), 1);
    clear();
    put(-128 * -128);
    chk("t6 n1 acc", 64'(acc2), 16384);
    chk("t6 n1 vld", 64'(vld[2]), 1);
    idle();

    // Back-pressure on the result port.
    clear();
    acc_rdy = 1'b0;
    put(1); put(2); put(3); put(4);
    chk("t3 acc", 64'(acc0), 10);
    prod = 16'sd999; prod_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3 hold rdy", 64'(rdy[0]), 0);
      chk("t3 hold acc", 64'(acc0), 10);
    end
    acc_rdy = 1'b1;
    @(negedge clk);
    prod_vld = 1'b0;
    chk("t3 rel rdy", 64'(rdy[0]), 1);
    chk("t3 rel acc", 64'(acc0), 0);
    chk("t3 rel cnt", 64'(cnt0), 0);
    idle();

    // Clear mid-frame drops the concurrent product.
    clear();
    put(-40); put(100);
    clr = 1'b1; prod = 16'sd500; prod_vld = 1'b1;
    @(negedge clk);
    clr = 1'b0; prod_vld = 1'b0;
    chk("t4 acc", 64'(acc0), 0);
    chk("t4 cnt", 64'(cnt0), 0);
    put(1); put(2); put(3); put(4);
    chk("t4 frame", 64'(acc0), 10);
    idle();

    // Reset mid-frame discards the partial sum.
    clear();
    put(5); put(6); put(7);
    rst_n = 1'b0; prod_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5 acc", 64'(acc0), 0);
    chk("t5 cnt", 64'(cnt0), 0);
    chk("t5 rdy", 64'(rdy[0]), 1);
    chk("t5 vld", 64'(vld[0]), 0);
    put(10); put(20); put(30); put(40);
    chk("t5 frame", 64'(acc0), 100);
    idle();

    // Random traffic, checked by the monitor against the model.
    for (int n = 0; n < 600; n++) begin
      prod     = 16'($urandom);
      prod_vld = ($urandom_range(0, 9) < 7);
      acc_rdy  = ($urandom_range(0, 9) < 6);
      clr      = ($urandom_range(0, 49) == 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; clr = 1'b0; prod_vld = 1'b0; acc_rdy = 1'b1;
    repeat (4) @(negedge clk);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb drain: got %0d pending results want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
